// File: rtl/lru_fifo.sv
// ============================================================================
//  Module   : lru_fifo
//  Purpose  : 4-entry true-LRU tracker plus show-ahead FIFO for the ISB
//             prefetcher. Optional `flush` port when LRU_FIFO_FLUSH_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lru_fifo #(
    parameter int LOG_DEPTH = 2,
    parameter int WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lru_v,
    input  logic [1:0]           lru_used,
    output logic [1:0]           lru_out,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   count
`ifdef LRU_FIFO_FLUSH_EN
    ,
    input  logic                 flush
`endif
);

    localparam int                 c_DEPTH   = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] c_FULL    = c_DEPTH[LOG_DEPTH:0];
    localparam logic [LOG_DEPTH:0] c_CNT_ONE = 1;
    localparam logic [LOG_DEPTH-1:0] c_PTR_ONE = 1;

    // ------------------------------------------------------------------
    // LRU tracker: ages are a permutation of 0..3, 3 = most recent
    // ------------------------------------------------------------------
    logic [1:0] r_age     [4];
    logic [1:0] w_age_nxt [4];
    logic [1:0] w_lru_idx;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_age_nxt[i] = r_age[i];
            if (lru_v) begin
                if (2'(i) == lru_used)
                    w_age_nxt[i] = 2'd3;
                else if (r_age[i] > r_age[lru_used])
                    w_age_nxt[i] = r_age[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                r_age[i] <= 2'(i);
        end else begin
            for (int i = 0; i < 4; i++)
                r_age[i] <= w_age_nxt[i];
        end
    end

    always_comb begin
        w_lru_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (r_age[i] == 2'd0)
                w_lru_idx = 2'(i);
    end

    assign lru_out = w_lru_idx;

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     r_mem [c_DEPTH];
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH:0]   r_count;
    logic                 w_flush;
    logic                 w_pop_ok;
    logic                 w_push_ok;

`ifdef LRU_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_push_ok = push && (!full || w_pop_ok) && !w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok)
            r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_lru_fifo.sv
// ============================================================================
//  Module   : tb_lru_fifo
//  Purpose  : Self-checking bench for lru_fifo (vector table, directed
//             corner sequences, randomized run against a queue-based model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lru_fifo;

    localparam int LOG_DEPTH = 2;
    localparam int WIDTH     = 16;
    localparam int DEPTH     = 1 << LOG_DEPTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             lru_v = 1'b0;
    logic [1:0]       lru_used = 2'd0;
    logic [1:0]       lru_out;
    logic             push = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] pop_data;
    logic             empty;
    logic             full;
    logic [LOG_DEPTH:0] count;
    logic             flush = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lru_fifo #(.LOG_DEPTH(LOG_DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .lru_v     (lru_v),
        .lru_used  (lru_used),
        .lru_out   (lru_out),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty),
        .full      (full),
        .count     (count)
`ifdef LRU_FIFO_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    typedef struct {
        logic        v;
        logic [1:0]  u;
        logic        ps;
        logic [15:0] d;
        logic        pp;
        logic [1:0]  e_lru;
        logic [2:0]  e_cnt;
        logic        chk_d;
        logic [15:0] e_d;
    } vec_t;

    vec_t tbl[21];

    // Behavioural model: LRU as an ordered list (oldest first), FIFO as a queue
    int          m_order[$];
    logic [15:0] m_fifo[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] u, input logic ps,
                       input logic [15:0] d, input logic pp, input logic rs,
                       input logic fl);
        lru_v = v; lru_used = u; push = ps; push_data = d; pop = pp;
        reset = rs; flush = fl;
        @(posedge clk);
        #1;
        lru_v = 1'b0; push = 1'b0; pop = 1'b0; reset = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] e_lru, input int e_cnt);
        chk({tag, "_lru"},   32'(lru_out), 32'(e_lru));
        chk({tag, "_count"}, 32'(count),   32'(e_cnt));
        chk({tag, "_empty"}, 32'(empty),   32'(e_cnt == 0));
        chk({tag, "_full"},  32'(full),    32'(e_cnt == DEPTH));
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] u, input logic ps,
                                input logic [15:0] d, input logic pp,
                                input logic [1:0] el, input logic [2:0] ec,
                                input logic cd, input logic [15:0] ed);
        vec_t r;
        r.v = v; r.u = u; r.ps = ps; r.d = d; r.pp = pp;
        r.e_lru = el; r.e_cnt = ec; r.chk_d = cd; r.e_d = ed;
        return r;
    endfunction

    task automatic model_reset();
        m_order = '{0, 1, 2, 3};
        m_fifo.delete();
    endtask

    task automatic model_step(input logic v, input logic [1:0] u, input logic ps,
                              input logic [15:0] d, input logic pp, input logic rs,
                              input logic fl);
        bit pop_ok, push_ok;
        if (rs) begin
            model_reset();
            return;
        end
        if (v) begin
            foreach (m_order[k])
                if (m_order[k] == int'(u)) begin
                    m_order.delete(k);
                    break;
                end
            m_order.push_back(int'(u));
        end
        if (fl) begin
            m_fifo.delete();
            return;
        end
        pop_ok  = pp && (m_fifo.size() > 0);
        push_ok = ps && ((m_fifo.size() < DEPTH) || pop_ok);
        if (pop_ok)  void'(m_fifo.pop_front());
        if (push_ok) m_fifo.push_back(d);
    endtask

    initial begin
        // LRU touches then FIFO fill/drain, each row one clock
        tbl[0]  = mk(0, 0, 0, 16'h0000, 0, 2'd0, 3'd0, 0, 16'h0000);
        tbl[1]  = mk(1, 0, 0, 16'h0000, 0, 2'd1, 3'd0, 0, 16'h0000);
        tbl[2]  = mk(1, 1, 0, 16'h0000, 0, 2'd2, 3'd0, 0, 16'h0000);
        tbl[3]  = mk(1, 2, 0, 16'h0000, 0, 2'd3, 3'd0, 0, 16'h0000);
        tbl[4]  = mk(1, 3, 0, 16'h0000, 0, 2'd0, 3'd0, 0, 16'h0000);
        tbl[5]  = mk(1, 3, 0, 16'h0000, 0, 2'd0, 3'd0, 0, 16'h0000);
        tbl[6]  = mk(1, 0, 0, 16'h0000, 0, 2'd1, 3'd0, 0, 16'h0000);
        tbl[7]  = mk(1, 0, 0, 16'h0000, 0, 2'd1, 3'd0, 0, 16'h0000);
        tbl[8]  = mk(0, 0, 1, 16'h1111, 0, 2'd1, 3'd1, 1, 16'h1111);
        tbl[9]  = mk(0, 0, 1, 16'h2222, 0, 2'd1, 3'd2, 1, 16'h1111);
        tbl[10] = mk(0, 0, 1, 16'h3333, 0, 2'd1, 3'd3, 1, 16'h1111);
        tbl[11] = mk(0, 0, 1, 16'h4444, 0, 2'd1, 3'd4, 1, 16'h1111);
        tbl[12] = mk(0, 0, 1, 16'h5555, 0, 2'd1, 3'd4, 1, 16'h1111);
        tbl[13] = mk(0, 0, 1, 16'h6666, 1, 2'd1, 3'd4, 1, 16'h2222);
        tbl[14] = mk(0, 0, 0, 16'h0000, 1, 2'd1, 3'd3, 1, 16'h3333);
        tbl[15] = mk(0, 0, 0, 16'h0000, 1, 2'd1, 3'd2, 1, 16'h4444);
        tbl[16] = mk(0, 0, 0, 16'h0000, 1, 2'd1, 3'd1, 1, 16'h6666);
        tbl[17] = mk(0, 0, 0, 16'h0000, 1, 2'd1, 3'd0, 0, 16'h0000);
        tbl[18] = mk(0, 0, 0, 16'h0000, 1, 2'd1, 3'd0, 0, 16'h0000);
        tbl[19] = mk(0, 0, 1, 16'h7777, 1, 2'd1, 3'd1, 1, 16'h7777);
        tbl[20] = mk(0, 0, 0, 16'h0000, 1, 2'd1, 3'd0, 0, 16'h0000);

        cyc(0, 0, 0, 16'h0, 0, 1, 0);
        cyc(0, 0, 0, 16'h0, 0, 1, 0);
        chk_state("reset", 2'd0, 0);

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].v, tbl[i].u, tbl[i].ps, tbl[i].d, tbl[i].pp, 0, 0);
            chk_state($sformatf("vec%0d", i), tbl[i].e_lru, int'(tbl[i].e_cnt));
            if (tbl[i].chk_d)
                chk($sformatf("vec%0d_data", i), 32'(pop_data), 32'(tbl[i].e_d));
        end

        // Alternating push/pop wraps the pointers several times
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 1, 16'hA000 + 16'(k), 0, 0, 0);
            chk($sformatf("alt%0d_data", k), 32'(pop_data), 32'(16'hA000 + 16'(k)));
            chk($sformatf("alt%0d_count", k), 32'(count), 32'd1);
            cyc(0, 0, 0, 16'h0, 1, 0, 0);
            chk($sformatf("alt%0d_empty", k), 32'(empty), 32'd1);
        end

        // Reset beats concurrent touch/push/pop with three entries queued
        cyc(0, 0, 1, 16'hB001, 0, 0, 0);
        cyc(0, 0, 1, 16'hB002, 0, 0, 0);
        cyc(1, 2, 1, 16'hB003, 0, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd3);
        cyc(1, 0, 1, 16'hB004, 1, 1, 0);
        chk_state("mid_rst", 2'd0, 0);
        cyc(0, 0, 0, 16'h0, 0, 0, 0);
        chk_state("post_rst", 2'd0, 0);

`ifdef LRU_FIFO_FLUSH_EN
        cyc(0, 0, 1, 16'hC001, 0, 0, 0);
        cyc(1, 1, 1, 16'hC002, 0, 0, 0);
        cyc(1, 0, 0, 16'h0, 0, 0, 0);
        chk_state("pre_flush", 2'd2, 2);
        cyc(0, 0, 1, 16'hAAAA, 0, 0, 1);
        chk_state("flush", 2'd2, 0);
        cyc(0, 0, 1, 16'hC003, 0, 0, 0);
        chk_state("post_flush", 2'd2, 1);
        chk("post_flush_data", 32'(pop_data), 32'(16'hC003));
`endif

        // Randomized run against the model
        cyc(0, 0, 0, 16'h0, 0, 1, 0);
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            logic       rv, rps, rpp, rrs, rfl;
            logic [1:0] ru;
            logic [15:0] rd;
            rv  = 1'($urandom_range(0, 1));
            ru  = 2'($urandom_range(0, 3));
            rps = ($urandom_range(0, 2) != 0);
            rd  = 16'($urandom);
            rpp = 1'($urandom_range(0, 1));
            rrs = ($urandom_range(0, 63) == 0);
`ifdef LRU_FIFO_FLUSH_EN
            rfl = ($urandom_range(0, 31) == 0);
`else
            rfl = 1'b0;
`endif
            cyc(rv, ru, rps, rd, rpp, rrs, rfl);
            model_step(rv, ru, rps, rd, rpp, rrs, rfl);
            chk_state($sformatf("rnd%0d", n), 2'(m_order[0]), m_fifo.size());
            if (m_fifo.size() > 0)
                chk($sformatf("rnd%0d_data", n), 32'(pop_data), 32'(m_fifo[0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lru_fifo.md
# lru_fifo

Support block for the ISB prefetcher. It combines two pieces in one clock domain:

- a 4-entry true-LRU replacement tracker, used by the training unit to pick its victim entry;
- a show-ahead FIFO, used as the stream-predictor's stream buffer queue.

All state is registered on `clk`; all outputs are driven from registered state only.

## Interface
Parameters:
- `LOG_DEPTH`, default 2: FIFO depth is 2^LOG_DEPTH entries (default 4).
- `WIDTH`, default 16: FIFO data width in bits (one physical address).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `lru_v`  in  1  touch strobe: this cycle, entry `lru_used` was accessed.
- `lru_used`  in  2  index of the accessed entry.
- `lru_out`  out  2  index of the least-recently-used entry.
- `push`  in  1  enqueue request.
- `push_data`  in  WIDTH  data to enqueue.
- `pop`  in  1  dequeue request.
- `pop_data`  out  WIDTH  head entry (show-ahead).
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds 2^LOG_DEPTH entries.
- `count`  out  LOG_DEPTH+1  number of occupied entries.
- `flush`  in  1  present only with `LRU_FIFO_FLUSH_EN`; see Configuration.

## Operation
LRU tracker:
- Keeps a 2-bit age per entry. Ages always form a permutation of 0..3; 3 means most recently used.
- Reset state: entry i has age i, so `lru_out` = 0 after reset.
- On a clock edge with `lru_v`=1 and touched entry u, where a = age[u]:
  - every entry with age greater than a decrements its age by 1;
  - age[u] becomes 3;
  - all other entries keep their age.
- Touching the entry that is already MRU changes nothing.
- `lru_out` = the index whose age is 0. Because ages are a permutation, exactly one index qualifies.
- `lru_v`=0: ages are held.

FIFO:
- Circular buffer with read pointer, write pointer and an occupancy counter.
- Push accepted only when `push`=1 and (not full, or a pop is accepted in the same cycle).
  - On accept: write `push_data` at the write pointer, then advance the write pointer.
- Pop accepted only when `pop`=1 and not empty.
  - On accept: advance the read pointer.
- Simultaneous push and pop:
  - when full: both are accepted and `count` stays at 2^LOG_DEPTH;
  - when empty: only the push is accepted, with no bypass; `count` becomes 1.
- Rejected requests are silently dropped. They change no state and have no error flag.
- Pointers wrap modulo 2^LOG_DEPTH.
- `pop_data` = contents at the read pointer. It is undefined (contents don't care) while empty.
- Reset: both pointers 0, `count` 0, `empty` 1, `full` 0. Storage contents are not reset.

## Timing
- LRU:
  - a touch at edge N is reflected in `lru_out` after edge N;
  - `lru_out` does not combinationally depend on `lru_v` or `lru_used`.
- FIFO:
  - a push at edge N makes the data visible on `pop_data` after edge N if the FIFO was empty, so latency is 1 cycle;
  - `empty`, `full` and `count` update after the edge that accepts the operation.
- `reset` takes priority over every other input in the same cycle, including `lru_v`, `push`, `pop` and `flush`.
- Reset asserted mid-operation discards queued data and restores the LRU permutation to its reset state on that edge.

## Configuration
- Macro `LRU_FIFO_FLUSH_EN`.
- Defined:
  - adds a 1-bit `flush` input;
  - on an edge with `flush`=1, both pointers and `count` clear to 0, used to retarget the stream buffer;
  - a push in the same cycle as `flush` is dropped;
  - LRU state is unaffected;
  - `reset` still has priority.
- Not defined:
  - the port does not exist;
  - the FIFO empties only by pops or `reset`.

## Test plan
- Reset, then hold `lru_v`=0 → `lru_out`=0. Touch 0, 1, 2 on successive cycles → `lru_out` = 1, 2, 3 after each edge respectively.
- From reset, touch 3 (the current MRU) → `lru_out` stays 0. Touch 0 then 0 → `lru_out`=1 and the permutation remains valid.
- Push 0x1111, 0x2222, 0x3333, 0x4444 → `full`=1, `count`=4. Push 0x5555 → dropped. Pop four times → reads 0x1111..0x4444 in order, then `empty`=1.
- With the FIFO full, push and pop in the same cycle → `count` stays 4 and the head advances. With the FIFO empty, push and pop in the same cycle → `count`=1 and `pop_data`=pushed value.
- 10 alternating push/pop cycles → pointers wrap and data order is preserved. Assert `reset` with 3 entries queued → `empty`=1 and `lru_out`=0 on the next cycle.
- With `LRU_FIFO_FLUSH_EN`: queue 2 entries, then flush + push 0xAAAA → `empty`=1 and the LRU is unchanged.
